// File: rtl/pipe_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_fsm
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges
// three hazard sources into one priority-ordered set of pipeline-register
// enables and bubble/flush controls:
//   - load-use hazard (ID),
//   - taken-branch redirect (EX),
//   - multi-cycle data-memory wait (MEM).
// Multi-cycle events are tracked by a three-state FSM. A saturating counter
// records every cycle in which the PC is held.
//
// Ports
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   IF_ID_RS1/RS2              source registers of the instruction in ID
//   ID_EX_MemRead/WriteReg     load flag and rd of the instruction in EX
//   Branch_Taken               EX resolved a taken branch/jump this cycle
//   Dmem_Req/Dmem_Ready        MEM-stage data-memory handshake
//   Cnt_Clr                    synchronous clear of Stall_Count
//   PC_En, IF_ID_En, ID_EX_En, EX_MEM_En      register load enables
//   IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble   NOP/bubble insertion
//   Mem_Err                    registered one-cycle pulse on memory timeout
//   Stall_Count                registered saturating count of PC_En=0 cycles
// ---------------------------------------------------------------------------
module pipe_ctrl_fsm #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IF_ID_RS1,
   input  logic [4:0]       IF_ID_RS2,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_WriteReg,
   input  logic             Branch_Taken,
   input  logic             Dmem_Req,
   input  logic             Dmem_Ready,
   input  logic             Cnt_Clr,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             IF_ID_Flush,
   output logic             ID_EX_En,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_En,
   output logic             MEM_WB_Bubble,
   output logic             Mem_Err,
   output logic [CNT_W-1:0] Stall_Count
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [TW-1:0]    TMO_LAST   = TW'(MEM_TIMEOUT);
   localparam logic [FW-1:0]    FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
   logic             ret_flush_q, ret_flush_d;   // MEM_WAIT was entered from FLUSH
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic mem_stall;
   logic eval_run;     // apply the RUN priority rules this cycle
   logic eval_flush;   // apply the FLUSH rules this cycle
   logic wait_hold;    // MEM_WAIT with memory still busy

   assign load_use  = ID_EX_MemRead && (ID_EX_WriteReg != 5'd0) &&
                      ((ID_EX_WriteReg == IF_ID_RS1) || (ID_EX_WriteReg == IF_ID_RS2));
   assign mem_stall = Dmem_Req && !Dmem_Ready;

   // On the Dmem_Ready cycle of a wait, the pipeline is evaluated as if
   // already back in the state the wait interrupted.
   assign wait_hold  = (state_q == ST_MEM_WAIT) && !Dmem_Ready;
   assign eval_run   = (state_q == ST_RUN) ||
                       ((state_q == ST_MEM_WAIT) && Dmem_Ready && !ret_flush_q);
   assign eval_flush = (state_q == ST_FLUSH) ||
                       ((state_q == ST_MEM_WAIT) && Dmem_Ready && ret_flush_q);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         tmo_cnt_q   <= '0;
         flush_cnt_q <= '0;
         ret_flush_q <= 1'b0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tmo_cnt_q   <= tmo_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         ret_flush_q <= ret_flush_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      flush_cnt_d = flush_cnt_q;
      ret_flush_d = ret_flush_q;
      mem_err_d   = 1'b0;

      if ((eval_run || eval_flush) && mem_stall) begin
         // Entry cycle already counts as the first frozen cycle; the flush
         // counter is left untouched so an interrupted flush can resume.
         if (MEM_TIMEOUT == 1) begin
            state_d     = ST_RUN;
            mem_err_d   = 1'b1;
            ret_flush_d = 1'b0;
            tmo_cnt_d   = '0;
         end else begin
            state_d     = ST_MEM_WAIT;
            tmo_cnt_d   = TW'(1);
            ret_flush_d = eval_flush;
         end
      end else if (eval_run) begin
         ret_flush_d = 1'b0;
         tmo_cnt_d   = '0;
         if (Branch_Taken && (FLUSH_CYCLES > 1)) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_INIT;
         end else begin
            state_d     = ST_RUN;
         end
      end else if (eval_flush) begin
         ret_flush_d = 1'b0;
         tmo_cnt_d   = '0;
         if (flush_cnt_q <= FW'(1)) begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
         end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = flush_cnt_q - FW'(1);
         end
      end else if (wait_hold) begin
         // Timeout fires at the end of the MEM_TIMEOUT-th frozen cycle.
         if ((tmo_cnt_q + TW'(1)) >= TMO_LAST) begin
            state_d     = ST_RUN;
            mem_err_d   = 1'b1;
            ret_flush_d = 1'b0;
            tmo_cnt_d   = '0;
            flush_cnt_d = '0;
         end else begin
            tmo_cnt_d   = tmo_cnt_q + TW'(1);
         end
      end else begin
         state_d = ST_RUN;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      PC_En         = 1'b1;
      IF_ID_En      = 1'b1;
      ID_EX_En      = 1'b1;
      EX_MEM_En     = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MEM_WB_Bubble = 1'b0;

      if (rst) begin
         PC_En         = 1'b0;
         IF_ID_En      = 1'b0;
         ID_EX_En      = 1'b0;
         EX_MEM_En     = 1'b0;
         IF_ID_Flush   = 1'b1;
         ID_EX_Flush   = 1'b1;
         MEM_WB_Bubble = 1'b1;
      end else if (wait_hold || ((eval_run || eval_flush) && mem_stall)) begin
         // Freeze everything up to MEM and drain a bubble into WB.
         PC_En         = 1'b0;
         IF_ID_En      = 1'b0;
         ID_EX_En      = 1'b0;
         EX_MEM_En     = 1'b0;
         MEM_WB_Bubble = 1'b1;
      end else if (eval_run && Branch_Taken) begin
         // Redirect wins over load-use: the dependent instruction is squashed.
         IF_ID_Flush   = 1'b1;
         ID_EX_Flush   = 1'b1;
      end else if (eval_run && load_use) begin
         PC_En         = 1'b0;
         IF_ID_En      = 1'b0;
         ID_EX_Flush   = 1'b1;
      end else if (eval_flush) begin
         // ID holds a NOP during FLUSH, so load-use cannot occur here.
         IF_ID_Flush   = 1'b1;
      end
   end

   // ---------------------------------------------------------------- stall counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (Cnt_Clr) begin
         stall_cnt_d = '0;
      end else if (!PC_En && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   assign Mem_Err     = mem_err_q;
   assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_fsm
//
// Directed bench for pipe_ctrl_fsm with FLUSH_CYCLES=3, MEM_TIMEOUT=8 and a
// 4-bit stall counter so saturation is reachable. Inputs change 1 time unit
// after the rising edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_fsm;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic [4:0]       IF_ID_RS1;
   logic [4:0]       IF_ID_RS2;
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_WriteReg;
   logic             Branch_Taken;
   logic             Dmem_Req;
   logic             Dmem_Ready;
   logic             Cnt_Clr;
   logic             PC_En;
   logic             IF_ID_En;
   logic             IF_ID_Flush;
   logic             ID_EX_En;
   logic             ID_EX_Flush;
   logic             EX_MEM_En;
   logic             MEM_WB_Bubble;
   logic             Mem_Err;
   logic [CNT_W-1:0] Stall_Count;

   // {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble}
   logic [6:0] ctl;
   assign ctl = {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble};

   localparam logic [6:0] C_NORMAL = 7'b1111_000;
   localparam logic [6:0] C_FREEZE = 7'b0000_001;
   localparam logic [6:0] C_BRANCH = 7'b1111_110;
   localparam logic [6:0] C_LDUSE  = 7'b0011_010;
   localparam logic [6:0] C_FLUSH  = 7'b1111_100;
   localparam logic [6:0] C_RESET  = 7'b0000_111;

   int n_pass  = 0;
   int n_total = 0;

   pipe_ctrl_fsm #(
      .FLUSH_CYCLES (3),
      .MEM_TIMEOUT  (8),
      .CNT_W        (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .IF_ID_RS1      (IF_ID_RS1),
      .IF_ID_RS2      (IF_ID_RS2),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_WriteReg (ID_EX_WriteReg),
      .Branch_Taken   (Branch_Taken),
      .Dmem_Req       (Dmem_Req),
      .Dmem_Ready     (Dmem_Ready),
      .Cnt_Clr        (Cnt_Clr),
      .PC_En          (PC_En),
      .IF_ID_En       (IF_ID_En),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_En       (ID_EX_En),
      .ID_EX_Flush    (ID_EX_Flush),
      .EX_MEM_En      (EX_MEM_En),
      .MEM_WB_Bubble  (MEM_WB_Bubble),
      .Mem_Err        (Mem_Err),
      .Stall_Count    (Stall_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
         $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      IF_ID_RS1      = 5'd0;
      IF_ID_RS2      = 5'd0;
      ID_EX_MemRead  = 1'b0;
      ID_EX_WriteReg = 5'd0;
      Branch_Taken   = 1'b0;
      Dmem_Req       = 1'b0;
      Dmem_Ready     = 1'b0;
      Cnt_Clr        = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // Reset state
      #3;
      chk("rst_ctl", 32'(ctl), 32'(C_RESET));
      chk("rst_cnt", 32'(Stall_Count), 32'd0);
      chk("rst_err", 32'(Mem_Err), 32'd0);
      settle();
      rst = 1'b0;
      #1;
      chk("idle_ctl", 32'(ctl), 32'(C_NORMAL));

      // Load-use on rs2
      cyc();
      ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd5; IF_ID_RS2 = 5'd5;
      settle();
      chk("lu_ctl", 32'(ctl), 32'(C_LDUSE));
      cyc();
      ID_EX_MemRead = 1'b0;
      settle();
      chk("lu_release", 32'(ctl), 32'(C_NORMAL));
      chk("lu_cnt", 32'(Stall_Count), 32'd1);

      // x0 never matches; unrelated registers never match
      cyc();
      ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd0; IF_ID_RS1 = 5'd0; IF_ID_RS2 = 5'd0;
      settle();
      chk("x0_ctl", 32'(ctl), 32'(C_NORMAL));
      cyc();
      ID_EX_WriteReg = 5'd7; IF_ID_RS1 = 5'd3; IF_ID_RS2 = 5'd4;
      settle();
      chk("nomatch_ctl", 32'(ctl), 32'(C_NORMAL));
      chk("x0_cnt", 32'(Stall_Count), 32'd1);

      // Branch together with load-use on rs1: branch wins, then 2 flush cycles
      cyc();
      ID_EX_WriteReg = 5'd5; IF_ID_RS1 = 5'd5; Branch_Taken = 1'b1;
      settle();
      chk("br_lu_ctl", 32'(ctl), 32'(C_BRANCH));
      cyc();
      idle_inputs();
      settle();
      chk("flush1_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      settle();
      chk("flush2_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      Cnt_Clr = 1'b1;
      settle();
      chk("flush_end", 32'(ctl), 32'(C_NORMAL));
      chk("br_cnt", 32'(Stall_Count), 32'd1);

      // Memory wait 4 cycles with branch held; branch acts on release cycle
      cyc();
      Cnt_Clr = 1'b0; Dmem_Req = 1'b1; Dmem_Ready = 1'b0; Branch_Taken = 1'b1;
      settle();
      chk("clr_cnt", 32'(Stall_Count), 32'd0);
      chk("mw1_ctl", 32'(ctl), 32'(C_FREEZE));
      for (int i = 0; i < 3; i++) begin
         cyc();
         settle();
         chk("mw_ctl", 32'(ctl), 32'(C_FREEZE));
      end
      cyc();
      Dmem_Ready = 1'b1;
      settle();
      chk("mw_rel_ctl", 32'(ctl), 32'(C_BRANCH));
      chk("mw_cnt", 32'(Stall_Count), 32'd4);
      cyc();
      idle_inputs();
      settle();
      chk("mw_fl1_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      settle();
      chk("mw_fl2_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      settle();
      chk("mw_run_ctl", 32'(ctl), 32'(C_NORMAL));

      // Memory stall inside FLUSH: freeze, then resume the remaining flush
      cyc();
      Branch_Taken = 1'b1;
      settle();
      chk("fw_br_ctl", 32'(ctl), 32'(C_BRANCH));
      cyc();
      Branch_Taken = 1'b0; Dmem_Req = 1'b1; Dmem_Ready = 1'b0;
      settle();
      chk("fw_frz1_ctl", 32'(ctl), 32'(C_FREEZE));
      cyc();
      settle();
      chk("fw_frz2_ctl", 32'(ctl), 32'(C_FREEZE));
      cyc();
      Dmem_Ready = 1'b1;
      settle();
      chk("fw_res1_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      idle_inputs();
      settle();
      chk("fw_res2_ctl", 32'(ctl), 32'(C_FLUSH));
      cyc();
      settle();
      chk("fw_run_ctl", 32'(ctl), 32'(C_NORMAL));

      // Timeout: 8 frozen cycles, then a single Mem_Err pulse in RUN
      cyc();
      Dmem_Req = 1'b1; Dmem_Ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("to_frz_ctl", 32'(ctl), 32'(C_FREEZE));
         chk("to_frz_err", 32'(Mem_Err), 32'd0);
         cyc();
      end
      Dmem_Req = 1'b0;
      settle();
      chk("to_err", 32'(Mem_Err), 32'd1);
      chk("to_run_ctl", 32'(ctl), 32'(C_NORMAL));
      cyc();
      Cnt_Clr = 1'b1;
      settle();
      chk("to_err_off", 32'(Mem_Err), 32'd0);

      // Saturation: continuous load-use stalls every cycle
      cyc();
      Cnt_Clr = 1'b0;
      ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd9; IF_ID_RS1 = 5'd9;
      for (int i = 0; i < 14; i++) cyc();
      settle();
      chk("sat_cnt14", 32'(Stall_Count), 32'd14);
      chk("sat_ctl", 32'(ctl), 32'(C_LDUSE));
      cyc();
      cyc();
      cyc();
      settle();
      chk("sat_cnt_max", 32'(Stall_Count), 32'd15);
      cyc();
      Cnt_Clr = 1'b1;
      cyc();
      Cnt_Clr = 1'b0;
      settle();
      chk("clr_prio_cnt", 32'(Stall_Count), 32'd0);
      cyc();
      idle_inputs();

      // Asynchronous reset between edges while in MEM_WAIT
      Dmem_Req = 1'b1; Dmem_Ready = 1'b0;
      cyc();
      cyc();
      settle();
      chk("ar_pre_ctl", 32'(ctl), 32'(C_FREEZE));
      #2;
      rst = 1'b1;
      #1;
      chk("ar_ctl", 32'(ctl), 32'(C_RESET));
      chk("ar_cnt", 32'(Stall_Count), 32'd0);
      idle_inputs();
      cyc();
      settle();
      rst = 1'b0;
      #1;
      chk("ar_rel_ctl", 32'(ctl), 32'(C_NORMAL));
      cyc();
      settle();
      chk("ar_run_ctl", 32'(ctl), 32'(C_NORMAL));
      chk("ar_run_cnt", 32'(Stall_Count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
